writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/cpu_pkg.sv | 14 +
 rtl/writeback_arbiter_if.sv | 17 +
 rtl/wb_fifo.sv | 54 +++++
 rtl/writeback_arbiter.sv | 96 +++++++++
 tb/tb_writeback_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back queue occupancy encoding.
package cpu_pkg;

  localparam int CPU_DATA_W     = 16;
  localparam int CPU_REG_ADDR_W = 5;

  // Occupancy of the 2-entry load queue; the encoding doubles as the count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Valid/ready result channel carrying a destination register index and data.
interface writeback_arbiter_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_REG_ADDR_W
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;

  modport master (output valid, rd, data, input ready);
  modport slave  (input valid, rd, data, output ready);

endinterface

// File: rtl/wb_fifo.sv
// Two-entry in-order queue for load results; head is always slot 0.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_arbiter_if.slave  push_bus,
  input  logic                pop_i,
  output logic [1:0]          count_o,
  output logic [ADDR_W-1:0]   head_rd_o,
  output logic [DATA_W-1:0]   head_data_o
);

  fifo_state_e state_q, state_d;
  logic [ADDR_W+DATA_W-1:0] mem_q [2];
  logic push, pop;

  assign push_bus.ready = (state_q != FULL);
  assign push           = push_bus.valid && push_bus.ready;
  assign pop            = pop_i && (state_q != EMPTY);

  assign count_o     = state_q;
  assign head_rd_o   = mem_q[0][ADDR_W+DATA_W-1:DATA_W];
  assign head_data_o = mem_q[0][DATA_W-1:0];

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case ({push, pop})
      2'b10:   state_d = (state_q == EMPTY) ? ONE : FULL;
      2'b01:   state_d = (state_q == FULL) ? ONE : EMPTY;
      default: state_d = state_q;
    endcase
  end

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: storage is not reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem_q[0] <= push ? {push_bus.rd, push_bus.data} : mem_q[1];
    end else if (push) begin
      mem_q[state_q[0]] <= {push_bus.rd, push_bus.data};
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the non-stallable ALU result port and the load port onto one register-file write port.
module writeback_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0] Write_data,
  output logic              RegWrite,
  output logic              overflow
);

  writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fifo_bus ();

  logic [1:0]        fifo_count;
  logic              fifo_pop;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overflow_q, overflow_d;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_bus    (fifo_bus.slave),
    .pop_i       (fifo_pop),
    .count_o     (fifo_count),
    .head_rd_o   (head_rd),
    .head_data_o (head_data)
  );

  assign fifo_bus.rd   = mem_rd;
  assign fifo_bus.data = mem_data;
  assign mem_ready     = fifo_bus.ready;

  // ALU wins outright; otherwise the queue head goes first, and a load only bypasses an empty queue.
  always_comb begin
    regwrite_d     = 1'b0;
    rd_d           = rd_q;
    data_d         = data_q;
    fifo_bus.valid = 1'b0;
    fifo_pop       = 1'b0;
    if (alu_valid) begin
      regwrite_d     = 1'b1;
      rd_d           = alu_rd;
      data_d         = alu_data;
      fifo_bus.valid = mem_valid;
    end else if (fifo_count == 2'd0) begin
      if (mem_valid) begin
        regwrite_d = 1'b1;
        rd_d       = mem_rd;
        data_d     = mem_data;
      end
    end else begin
      regwrite_d     = 1'b1;
      rd_d           = head_rd;
      data_d         = head_data;
      fifo_pop       = 1'b1;
      fifo_bus.valid = mem_valid;
    end
    overflow_d = overflow_q | (mem_valid & ~mem_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign Rd         = rd_q;
  assign Write_data = data_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenarios plus randomized traffic against a queue-based write-back model.
module tb_writeback_arbiter;
  import cpu_pkg::*;

  localparam int DW = CPU_DATA_W;
  localparam int AW = CPU_REG_ADDR_W;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ld_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic [AW-1:0] Rd;
  logic [DW-1:0] Write_data;
  logic          RegWrite;
  logic          overflow;

  writeback_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) ld ();

  always #5 clk = ~clk;

  writeback_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (ld.valid),
    .mem_rd     (ld.rd),
    .mem_data   (ld.data),
    .mem_ready  (ld.ready),
    .Rd         (Rd),
    .Write_data (Write_data),
    .RegWrite   (RegWrite),
    .overflow   (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  ld_t           exp_q[$];
  logic          exp_we;
  logic [AW-1:0] exp_rd;
  logic [DW-1:0] exp_data;
  logic          exp_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    exp_ovf  = 1'b0;
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld.valid  = 1'b0;
    ld.rd     = '0;
    ld.data   = '0;
  endtask

  // One clock of traffic: drive, check ready, advance the model, check outputs after the edge.
  task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                      input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdat);
    bit  room;
    ld_t h;
    @(negedge clk);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = adat;
    ld.valid  = mv;
    ld.rd     = mrd;
    ld.data   = mdat;
    #1;
    room = (exp_q.size() < 2);
    check("mem_ready", 32'(ld.ready), 32'(room));
    if (mv && !room) exp_ovf = 1'b1;
    if (av) begin
      exp_we   = 1'b1;
      exp_rd   = ard;
      exp_data = adat;
      if (mv && room) exp_q.push_back('{rd: mrd, data: mdat});
    end else if (exp_q.size() == 0) begin
      exp_we = mv;
      if (mv) begin
        exp_rd   = mrd;
        exp_data = mdat;
      end
    end else begin
      h        = exp_q.pop_front();
      exp_we   = 1'b1;
      exp_rd   = h.rd;
      exp_data = h.data;
      if (mv && room) exp_q.push_back('{rd: mrd, data: mdat});
    end
    @(posedge clk);
    #1;
    check("RegWrite", 32'(RegWrite), 32'(exp_we));
    check("Rd", 32'(Rd), 32'(exp_rd));
    check("Write_data", 32'(Write_data), 32'(exp_data));
    check("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asserts reset between edges and checks the outputs clear without waiting for a clock.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_Rd", 32'(Rd), 32'd0);
    check("rst_Write_data", 32'(Write_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_mem_ready", 32'(ld.ready), 32'd1);
    model_clear();
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_RegWrite", 32'(RegWrite), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    model_clear();
    #12;
    check("init_RegWrite", 32'(RegWrite), 32'd0);
    check("init_Rd", 32'(Rd), 32'd0);
    check("init_Write_data", 32'(Write_data), 32'd0);
    check("init_overflow", 32'(overflow), 32'd0);
    check("init_mem_ready", 32'(ld.ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_RegWrite", 32'(RegWrite), 32'd0);

    // Bypass of a load into an empty queue.
    step(1'b0, '0, '0, 1'b1, 5'd3, 16'h1234);
    check("bypass_Rd", 32'(Rd), 32'd3);
    check("bypass_data", 32'(Write_data), 32'h1234);
    idle();
    check("bypass_idle_hold_Rd", 32'(Rd), 32'd3);

    // Collision: ALU first, the load the cycle after.
    step(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'hBBBB);
    check("collide_alu_Rd", 32'(Rd), 32'd1);
    idle();
    check("collide_mem_Rd", 32'(Rd), 32'd2);
    check("collide_mem_data", 32'(Write_data), 32'hBBBB);
    idle();

    // Simultaneous push and pop with one entry queued.
    step(1'b1, 5'd9, 16'h0909, 1'b1, 5'd7, 16'h0707);
    step(1'b0, '0, '0, 1'b1, 5'd8, 16'h0808);
    check("pushpop_Rd7", 32'(Rd), 32'd7);
    idle();
    check("pushpop_Rd8", 32'(Rd), 32'd8);
    idle();

    // Fill: two loads queue, the third is dropped and flags overflow.
    step(1'b1, 5'd10, 16'h1010, 1'b1, 5'd4, 16'h0404);
    step(1'b1, 5'd11, 16'h1111, 1'b1, 5'd5, 16'h0505);
    step(1'b1, 5'd12, 16'h1212, 1'b1, 5'd6, 16'h0606);
    check("fill_overflow", 32'(overflow), 32'd1);
    step(1'b1, 5'd0, 16'h0000, 1'b0, '0, '0);
    idle();
    check("drain_Rd4", 32'(Rd), 32'd4);
    idle();
    check("drain_Rd5", 32'(Rd), 32'd5);
    idle();
    check("drain_done", 32'(RegWrite), 32'd0);

    // Reset with a full queue and a write in flight.
    async_reset();
    step(1'b1, 5'd13, 16'h1313, 1'b1, 5'd14, 16'h1414);
    step(1'b1, 5'd15, 16'h1515, 1'b1, 5'd16, 16'h1616);
    check("prerst_mem_ready", 32'(ld.ready), 32'd0);
    async_reset();
    idle();
    idle();

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      if ((i % 150) == 149) async_reset();
      step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           1'($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
